// File: rtl/serializer_stream.sv
// Parallel-to-serial stream converter: one LANES x WIDTH beat in, words out lane 0 first.
// Ports: CLK, RESET (async, high), IN_DATA/IN_COUNT/IN_VALID/IN_READY beat side,
// OUT_DATA/OUT_VALID/OUT_READY word side; OUT_LAST when SERIALIZER_STREAM_LAST_EN is defined.
module serializer_stream #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES+1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [LANES*WIDTH-1:0] IN_DATA,
  input  logic [CNT_W-1:0]   IN_COUNT,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [WIDTH-1:0]   OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY
`ifdef SERIALIZER_STREAM_LAST_EN
  ,
  output logic               OUT_LAST
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_buf [LANES];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_idx_n;
  logic [CNT_W-1:0] w_eff;
  logic             w_last;
  logic             w_out_hs;
  logic             w_in_hs;

  assign w_last    = (r_idx == r_cnt - CNT_W'(1));
  assign OUT_VALID = (r_state == SHIFT);
  assign w_out_hs  = OUT_VALID & OUT_READY;
  // Final word leaving frees the buffer in the same cycle: no bubble.
  assign IN_READY  = (r_state == IDLE) | (w_out_hs & w_last);
  assign w_in_hs   = IN_VALID & IN_READY;

`ifdef SERIALIZER_STREAM_LAST_EN
  assign OUT_LAST  = OUT_VALID & w_last;
`endif

  // Zero or out-of-range counts mean a full beat.
  always_comb begin
    w_eff = CNT_W'(LANES);
    if (IN_COUNT != '0 && IN_COUNT <= CNT_W'(LANES))
      w_eff = IN_COUNT;
  end

  // idx parks on the last word when idle, so OUT_DATA keeps it.
  always_comb begin
    OUT_DATA = '0;
    for (int k = 0; k < LANES; k++)
      if (r_idx == CNT_W'(k))
        OUT_DATA = r_buf[k];
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    priority case (1'b1)
      w_in_hs: begin
        w_state_n = SHIFT;
        w_idx_n   = '0;
        w_cnt_n   = w_eff;
      end
      w_out_hs && w_last: w_state_n = IDLE;
      w_out_hs: w_idx_n = r_idx + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      for (int k = 0; k < LANES; k++)
        r_buf[k] <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      if (w_in_hs)
        for (int k = 0; k < LANES; k++)
          r_buf[k] <= IN_DATA[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_serializer_stream.sv
// Directed table-driven bench for serializer_stream (WIDTH=16, LANES=4).
// Per-cycle vectors plus a hand-written asynchronous reset sequence.
module tb_serializer_stream;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 3;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic [LANES*WIDTH-1:0] IN_DATA;
  logic [CNT_W-1:0]       IN_COUNT;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [WIDTH-1:0]       OUT_DATA;
  logic                   OUT_VALID;
  logic                   OUT_READY;
`ifdef SERIALIZER_STREAM_LAST_EN
  logic                   OUT_LAST;
`endif

  serializer_stream #(
    .WIDTH(WIDTH),
    .LANES(LANES)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_DATA  (IN_DATA),
    .IN_COUNT (IN_COUNT),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
`ifdef SERIALIZER_STREAM_LAST_EN
    ,
    .OUT_LAST (OUT_LAST)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
    logic        iv;
    logic        ordy;
    logic        eov;
    logic [15:0] eod;
    logic        eir;
    logic        elast;
  } vec_t;

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] D  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [63:0] A  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
  localparam logic [63:0] B  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
  localparam logic [63:0] C  = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
  localparam logic [63:0] E  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
  localparam logic [63:0] S0 = {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h0100};
  localparam logic [63:0] S1 = {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h0101};
  localparam logic [63:0] S2 = {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h0102};

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void v(input logic [63:0] d, input logic [2:0] c,
                            input logic iv, input logic ordy,
                            input logic eov, input logic [15:0] eod,
                            input logic eir, input logic elast);
    vec_t t;
    t.d = d; t.c = c; t.iv = iv; t.ordy = ordy;
    t.eov = eov; t.eod = eod; t.eir = eir; t.elast = elast;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic eov,
                           input logic [15:0] eod, input logic eir,
                           input logic elast);
    chk({nm, " OUT_VALID"}, 64'(OUT_VALID), 64'(eov));
    chk({nm, " IN_READY"}, 64'(IN_READY), 64'(eir));
    if (eov)
      chk({nm, " OUT_DATA"}, 64'(OUT_DATA), 64'(eod));
`ifdef SERIALIZER_STREAM_LAST_EN
    chk({nm, " OUT_LAST"}, 64'(OUT_LAST), 64'(elast));
`else
    if (elast === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic [63:0] d, input logic [2:0] c,
                       input logic iv, input logic ordy);
    IN_DATA = d; IN_COUNT = c; IN_VALID = iv; OUT_READY = ordy;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // basic full beat
    v(D,4,1,1, 0,16'h0,   1,0);
    v(Z,4,0,1, 1,16'h1111,0,0);
    v(Z,4,0,1, 1,16'h2222,0,0);
    v(Z,4,0,1, 1,16'h3333,0,0);
    v(Z,4,0,1, 1,16'h4444,1,1);
    v(Z,4,0,1, 0,16'h0,   1,0);
    // back-to-back beats
    v(A,4,1,1, 0,16'h0,   1,0);
    v(B,4,1,1, 1,16'hA000,0,0);
    v(B,4,1,1, 1,16'hA001,0,0);
    v(B,4,1,1, 1,16'hA002,0,0);
    v(B,4,1,1, 1,16'hA003,1,1);
    v(Z,4,0,1, 1,16'hB000,0,0);
    v(Z,4,0,1, 1,16'hB001,0,0);
    v(Z,4,0,1, 1,16'hB002,0,0);
    v(Z,4,0,1, 1,16'hB003,1,1);
    v(Z,4,0,1, 0,16'h0,   1,0);
    // backpressure on word 1
    v(D,4,1,1, 0,16'h0,   1,0);
    v(Z,4,0,1, 1,16'h1111,0,0);
    v(Z,4,0,0, 1,16'h2222,0,0);
    v(Z,4,0,0, 1,16'h2222,0,0);
    v(Z,4,0,0, 1,16'h2222,0,0);
    v(Z,4,0,1, 1,16'h2222,0,0);
    v(Z,4,0,1, 1,16'h3333,0,0);
    v(Z,4,0,1, 1,16'h4444,1,1);
    v(Z,4,0,1, 0,16'h0,   1,0);
    // partial count 2, stall on the last word with a beat waiting
    v(D,2,1,1, 0,16'h0,   1,0);
    v(Z,2,0,1, 1,16'h1111,0,0);
    v(D,2,1,0, 1,16'h2222,0,1);
    v(Z,2,0,1, 1,16'h2222,1,1);
    v(Z,2,0,1, 0,16'h0,   1,0);
    // count 0 clamps to full
    v(D,0,1,1, 0,16'h0,   1,0);
    v(Z,0,0,1, 1,16'h1111,0,0);
    v(Z,0,0,1, 1,16'h2222,0,0);
    v(Z,0,0,1, 1,16'h3333,0,0);
    v(Z,0,0,1, 1,16'h4444,1,1);
    v(Z,0,0,1, 0,16'h0,   1,0);
    // count 7 clamps to full
    v(C,7,1,1, 0,16'h0,   1,0);
    v(Z,7,0,1, 1,16'h5555,0,0);
    v(Z,7,0,1, 1,16'h6666,0,0);
    v(Z,7,0,1, 1,16'h7777,0,0);
    v(Z,7,0,1, 1,16'h8888,1,1);
    v(Z,7,0,1, 0,16'h0,   1,0);
    // single lane, one beat per cycle
    v(S0,1,1,1, 0,16'h0,   1,0);
    v(S1,1,1,1, 1,16'h0100,1,1);
    v(S2,1,1,1, 1,16'h0101,1,1);
    v(Z, 1,0,1, 1,16'h0102,1,1);
    v(Z, 1,0,1, 0,16'h0,   1,0);

    RESET = 1'b1;
    drive(Z, 3'd4, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    check_out("reset", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("reset OUT_DATA", 64'(OUT_DATA), 64'h0);
    RESET = 1'b0;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].d, vecs[i].c, vecs[i].iv, vecs[i].ordy);
      #4;
      check_out($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod,
                vecs[i].eir, vecs[i].elast);
      next_cycle();
    end

    // asynchronous reset in the middle of a beat
    drive(D, 3'd4, 1'b1, 1'b1);
    #4;
    check_out("rst cap", 1'b0, 16'h0, 1'b1, 1'b0);
    next_cycle();
    drive(Z, 3'd4, 1'b0, 1'b1);
    #4;
    check_out("rst w0", 1'b1, 16'h1111, 1'b0, 1'b0);
    next_cycle();
    #4;
    check_out("rst w1", 1'b1, 16'h2222, 1'b0, 1'b0);
    RESET = 1'b1;
    #1;
    check_out("rst async", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("rst async OUT_DATA", 64'(OUT_DATA), 64'h0);
    next_cycle();
    RESET = 1'b0;
    #4;
    check_out("rst rel", 1'b0, 16'h0, 1'b1, 1'b0);
    next_cycle();
    drive(E, 3'd4, 1'b1, 1'b1);
    #4;
    check_out("post cap", 1'b0, 16'h0, 1'b1, 1'b0);
    next_cycle();
    drive(Z, 3'd4, 1'b0, 1'b1);
    #4;
    check_out("post w0", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    next_cycle();
    #4;
    check_out("post w1", 1'b1, 16'hBBBB, 1'b0, 1'b0);
    next_cycle();
    #4;
    check_out("post w2", 1'b1, 16'hCCCC, 1'b0, 1'b0);
    next_cycle();
    #4;
    check_out("post w3", 1'b1, 16'hDDDD, 1'b1, 1'b1);
    next_cycle();
    #4;
    check_out("post idle", 1'b0, 16'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
